note_lane_scheduler: RTL and testbench

Sequences the falling-note display lanes. It decides what enters the top of each of the seven note lanes, and when the lanes advance. Note sources are live keyboard input (free mode) and a song reader driven through a req/ack handshake (autoplay mode). Lane advance is tied to a frame-aligned step tick, so scrolling never tears mid-frame. The block sits between the keyboard/song-ROM logic and the lane shift-register display renderer, which consumes `lane_note` on every `shift_en` pulse.

---
 rtl/note_lane_scheduler_pkg.sv | 37 +++
 rtl/note_lane_scheduler_step_timer.sv | 27 ++
 rtl/note_lane_scheduler.sv | 125 ++++++++++++
 tb/tb_note_lane_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_lane_scheduler_pkg.sv
// Shared definitions for the note lane scheduler: mode codes, FSM states,
// note bit positions and the lane mask.
package note_lane_scheduler_pkg;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_FREE = 2'b01;
  localparam logic [1:0] MODE_AUTO = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FREE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_END   = 3'd5
  } state_t;

  localparam int NOTE_C = 7;
  localparam int NOTE_D = 6;
  localparam int NOTE_E = 5;
  localparam int NOTE_F = 4;
  localparam int NOTE_G = 3;
  localparam int NOTE_A = 2;
  localparam int NOTE_B = 1;

  localparam logic [7:0] NOTE_MASK = 8'hFE;

  // Where a mode selection leads; mode 11 is treated as idle.
  function automatic state_t mode_target(input logic [1:0] mode);
    case (mode)
      MODE_FREE: return ST_FREE;
      MODE_AUTO: return ST_FETCH;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/note_lane_scheduler_step_timer.sv
// Frame divider: one tick every FRAMES_PER_STEP unpaused frame_start pulses.
// tick is combinational with frame_start so the lane load lands on that edge.
module note_lane_scheduler_step_timer #(
  parameter int FRAMES_PER_STEP = 2
) (
  input  logic vga_clk,
  input  logic rst_n,
  input  logic frame_start,
  input  logic pause,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(FRAMES_PER_STEP - 1);

  logic [7:0] frame_cnt;

  assign tick = frame_start && !pause && (frame_cnt == LAST);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_start && !pause) begin
      frame_cnt <= tick ? 8'd0 : frame_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/note_lane_scheduler.sv
// Decides what enters the top of the note lanes on each frame-aligned step
// tick: live keys (free mode) or song entries fetched via req/ack (autoplay).
module note_lane_scheduler
  import note_lane_scheduler_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2,
  parameter int GAP_STEPS       = 1,
  parameter int DUR_W           = 8
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [1:0]       mode,
  input  logic             pause,
  input  logic [7:0]       key_note,
  output logic             song_req,
  input  logic             song_ack,
  input  logic [7:0]       song_note,
  input  logic [DUR_W-1:0] song_dur,
  output logic [7:0]       lane_note,
  output logic             shift_en,
  output logic             song_done,
  output logic [2:0]       fsm_state
);

  localparam int GAP_W = (GAP_STEPS > 0) ? $clog2(GAP_STEPS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_STEPS > 0) ? GAP_STEPS - 1 : 0);

  state_t           state, state_nxt;
  logic             tick;
  logic             done_nxt;
  logic             load_note;
  logic [7:0]       lane_nxt;
  logic [7:0]       note_q;
  logic [DUR_W-1:0] dur_cnt;
  logic [GAP_W-1:0] gap_cnt;

  note_lane_scheduler_step_timer #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP)
  ) u_step_timer (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pause       (pause),
    .tick        (tick)
  );

  // Handshake: song_req is high for exactly the cycles spent in FETCH; the
  // reader answers with a one-cycle song_ack carrying song_note/song_dur, and
  // the edge that samples the ack leaves FETCH, so the request never drops
  // before the ack and an ack outside FETCH is ignored.
  assign song_req  = (state == ST_FETCH);
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    load_note = 1'b0;
    lane_nxt  = 8'h00;
    case (state)
      ST_IDLE: state_nxt = mode_target(mode);
      ST_FREE: begin
        lane_nxt = key_note & NOTE_MASK;
        if (mode != MODE_FREE) state_nxt = mode_target(mode);
      end
      ST_FETCH: begin
        // A tick here is an underrun and loads blank; the ack is still taken.
        if (song_ack) begin
          if (mode != MODE_AUTO) begin
            state_nxt = mode_target(mode);
          end else if (song_dur == '0) begin
            done_nxt  = 1'b1;
            state_nxt = ST_END;
          end else begin
            load_note = 1'b1;
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (mode != MODE_AUTO) begin
          state_nxt = mode_target(mode);
        end else begin
          lane_nxt = note_q;
          if (tick && dur_cnt == DUR_W'(1)) state_nxt = (GAP_STEPS > 0) ? ST_GAP : ST_FETCH;
        end
      end
      ST_GAP: begin
        if (mode != MODE_AUTO) state_nxt = mode_target(mode);
        else if (tick && gap_cnt == GAP_LAST) state_nxt = ST_FETCH;
      end
      ST_END: if (mode != MODE_AUTO) state_nxt = mode_target(mode);
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_note <= 8'h00;
      shift_en  <= 1'b0;
      song_done <= 1'b0;
      note_q    <= 8'h00;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      shift_en  <= tick;
      song_done <= done_nxt;
      if (tick) lane_note <= lane_nxt;
      if (load_note) begin
        note_q  <= song_note & NOTE_MASK;
        dur_cnt <= song_dur;
      end else if (tick && state == ST_HOLD && mode == MODE_AUTO && dur_cnt != '0) begin
        dur_cnt <= dur_cnt - DUR_W'(1);
      end
      if (state != ST_GAP) gap_cnt <= '0;
      else if (tick)       gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Bench for note_lane_scheduler: directed scenarios plus randomized traffic,
// every output compared each cycle against a queue-based reference model.
module tb_note_lane_scheduler;
  import note_lane_scheduler_pkg::*;

  localparam int FPS   = 2;
  localparam int GAP   = 1;
  localparam int DUR_W = 8;

  logic             vga_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_start = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             pause = 1'b0;
  logic [7:0]       key_note = 8'h00;
  logic             song_req;
  logic             song_ack = 1'b0;
  logic [7:0]       song_note = 8'h00;
  logic [DUR_W-1:0] song_dur = '0;
  logic [7:0]       lane_note;
  logic             shift_en;
  logic             song_done;
  logic [2:0]       fsm_state;

  note_lane_scheduler #(
    .FRAMES_PER_STEP(FPS),
    .GAP_STEPS(GAP),
    .DUR_W(DUR_W)
  ) dut (
    .vga_clk     (vga_clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .mode        (mode),
    .pause       (pause),
    .key_note    (key_note),
    .song_req    (song_req),
    .song_ack    (song_ack),
    .song_note   (song_note),
    .song_dur    (song_dur),
    .lane_note   (lane_note),
    .shift_en    (shift_en),
    .song_done   (song_done),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  always #5 vga_clk = ~vga_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: lane values queued per song entry, popped on ticks
  int         m_fcnt;
  int         m_src;     // 0 idle, 1 free, 2 autoplay, 3 song ended
  logic [7:0] m_q[$];
  logic [7:0] e_lane;
  logic       e_shift, e_req, e_done;

  function automatic int tgt(input logic [1:0] md);
    if (md == 2'b01) return 1;
    if (md == 2'b10) return 2;
    return 0;
  endfunction

  always @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fcnt = 0; m_src = 0; m_q.delete();
      e_lane = 8'h00; e_shift = 1'b0; e_req = 1'b0; e_done = 1'b0;
    end else begin
      logic tk;
      logic waiting;
      tk = 1'b0;
      if (frame_start && !pause) begin
        if (m_fcnt == FPS - 1) begin tk = 1'b1; m_fcnt = 0; end
        else m_fcnt++;
      end
      waiting = (m_src == 2) && (m_q.size() == 0);
      e_done  = 1'b0;
      e_shift = tk;
      if (tk) begin
        if (m_src == 1) e_lane = key_note & 8'hFE;
        else if (m_src == 2 && mode == 2'b10 && m_q.size() > 0) e_lane = m_q.pop_front();
        else e_lane = 8'h00;
      end
      case (m_src)
        0: m_src = tgt(mode);
        1: if (mode != 2'b01) m_src = tgt(mode);
        2: begin
          if (waiting) begin
            if (song_ack) begin
              if (mode != 2'b10) m_src = tgt(mode);
              else if (song_dur == 0) begin e_done = 1'b1; m_src = 3; end
              else begin
                for (int i = 0; i < int'(song_dur); i++) m_q.push_back(song_note & 8'hFE);
                for (int i = 0; i < GAP; i++) m_q.push_back(8'h00);
              end
            end
          end else if (mode != 2'b10) begin
            m_q.delete();
            m_src = tgt(mode);
          end
        end
        default: if (mode != 2'b10) m_src = tgt(mode);
      endcase
      e_req = (m_src == 2) && (m_q.size() == 0);
    end
  end

  // scoreboard: per-cycle compare plus a log of loaded lane values
  logic [7:0] lane_log[$];
  logic [7:0] exp_q[$];
  int         done_cnt = 0;

  always @(negedge vga_clk) begin
    check("lane_note", lane_note, e_lane);
    check("shift_en", shift_en, e_shift);
    check("song_req", song_req, e_req);
    check("song_done", song_done, e_done);
    if (shift_en) lane_log.push_back(lane_note);
    if (song_done) done_cnt++;
  end

  // song reader: answers requests after a delay, optional stray acks
  logic [15:0] sng_q[$];
  logic        ack_hold = 1'b0;
  logic        rand_delay = 1'b0;
  logic        spurious_en = 1'b0;
  int          rd_delay = 1;
  int          ack_wait = 0;

  always @(negedge vga_clk) begin
    logic [15:0] ent;
    song_ack = 1'b0;
    if (!rst_n) begin
      ack_wait = rd_delay;
    end else if (song_req && !ack_hold) begin
      if (ack_wait > 0) ack_wait--;
      else begin
        if (sng_q.size() > 0) ent = sng_q.pop_front();
        else ent = {8'($urandom), ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 4))};
        song_note = ent[15:8];
        song_dur  = ent[7:0];
        song_ack  = 1'b1;
        ack_wait  = rand_delay ? $urandom_range(0, 12) : rd_delay;
      end
    end else if (!song_req && spurious_en && $urandom_range(0, 40) == 0) begin
      song_note = 8'($urandom);
      song_dur  = '0;
      song_ack  = 1'b1;
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge vga_clk);
  endtask

  task automatic frames(input int n, input int spacing);
    for (int i = 0; i < n; i++) begin
      @(negedge vga_clk);
      frame_start = 1'b1;
      @(negedge vga_clk);
      frame_start = 1'b0;
      repeat (spacing - 2) @(negedge vga_clk);
    end
  endtask

  task automatic do_reset();
    @(negedge vga_clk);
    #2;
    rst_n = 1'b0;
    mode = 2'b00; pause = 1'b0; frame_start = 1'b0; key_note = 8'h00;
    ack_hold = 1'b0; sng_q.delete();
    cycles(2);
    #2;
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic clear_log();
    #1;
    lane_log.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  task automatic compare_log(input string tag);
    #1;
    check({tag, "_count"}, lane_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < lane_log.size(); i++)
      check(tag, lane_log[i], exp_q[i]);
  endtask

  task automatic wait_req(input int max);
    int k = 0;
    while (!song_req && k < max) begin
      @(negedge vga_clk);
      k++;
    end
    #1;
    check("req_wait", song_req, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #3;
    check("rst_lane", lane_note, 8'h00);
    check("rst_req", song_req, 1'b0);
    check("rst_state", fsm_state, ST_IDLE);

    // free mode: six frames give three ticks, bit0 masked
    do_reset();
    mode = 2'b01;
    key_note = (8'h01 << NOTE_C) | 8'h01;
    cycles(2);
    clear_log();
    frames(6, 4);
    exp_q = '{8'h80, 8'h80, 8'h80};
    compare_log("free_lane");

    // autoplay song with one gap step per note
    rd_delay = 1;
    do_reset();
    clear_log();
    sng_q = '{16'h4003, 16'h4002, 16'h0000};
    mode = 2'b10;
    cycles(3);
    frames(16, 8);
    exp_q = '{8'h40, 8'h40, 8'h40, 8'h00, 8'h40, 8'h40, 8'h00, 8'h00};
    compare_log("auto_lane");
    check("auto_done_cnt", done_cnt, 1);

    // delayed ack: two underrun ticks, then the note
    do_reset();
    ack_hold = 1'b1;
    mode = 2'b10;
    wait_req(10);
    clear_log();
    frames(4, 4);
    sng_q.push_back(16'h1001);
    ack_hold = 1'b0;
    cycles(3);
    frames(2, 4);
    exp_q = '{8'h00, 8'h00, 8'h10};
    compare_log("underrun_lane");

    // pause during HOLD with two steps left
    do_reset();
    sng_q = '{16'h2004, 16'h0000};
    mode = 2'b10;
    cycles(4);
    clear_log();
    frames(4, 4);
    pause = 1'b1;
    frames(5, 4);
    #1;
    check("pause_no_shift", lane_log.size(), 2);
    check("pause_lane_hold", lane_note, 8'h20);
    pause = 1'b0;
    frames(6, 4);
    exp_q = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00};
    compare_log("pause_lane");

    // mode change while FETCH waits: ack discarded, then keys
    do_reset();
    ack_hold = 1'b1;
    sng_q.push_back(16'h7700);
    mode = 2'b10;
    wait_req(10);
    mode = 2'b01;
    key_note = 8'h0F;
    cycles(5);
    #1;
    check("switch_req_held", song_req, 1'b1);
    clear_log();
    ack_hold = 1'b0;
    cycles(4);
    #1;
    check("switch_req_drop", song_req, 1'b0);
    check("switch_no_done", done_cnt, 0);
    frames(2, 4);
    exp_q = '{8'h0E};
    compare_log("switch_lane");

    // reset mid-HOLD, autoplay restarts with FETCH
    do_reset();
    sng_q.push_back(16'h6005);
    mode = 2'b10;
    cycles(4);
    frames(4, 4);
    #1;
    check("hold_before_rst", lane_note, 8'h60);
    @(negedge vga_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_lane", lane_note, 8'h00);
    check("arst_req", song_req, 1'b0);
    check("arst_state", fsm_state, ST_IDLE);
    cycles(2);
    #2;
    rst_n = 1'b1;
    #1;
    check("rel_req_low", song_req, 1'b0);
    @(negedge vga_clk);
    #1;
    check("rel_req_high", song_req, 1'b1);

    // randomized traffic against the model
    do_reset();
    rand_delay = 1'b1;
    spurious_en = 1'b1;
    for (int s = 0; s < 40; s++) begin
      mode = 2'($urandom_range(0, 3));
      for (int f = 0; f < int'($urandom_range(8, 24)); f++) begin
        key_note = 8'($urandom);
        pause = ($urandom_range(0, 7) == 0);
        frames(1, $urandom_range(2, 6));
      end
      if ($urandom_range(0, 9) == 0) begin
        @(negedge vga_clk);
        #2;
        rst_n = 1'b0;
        cycles(1);
        #2;
        rst_n = 1'b1;
      end
    end
    pause = 1'b0;
    cycles(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
